gcd_stream_engine: RTL and testbench
====================================

// Module: gcd_stream_engine
// PURPOSE
//  Parametrised successor to the single-shot GCD core: computes unsigned GCD(a,b) for W-bit operands.
//  Per-request runtime mode selects the subtractive (Euclid) or binary (Stein) algorithm.
//  Ready/valid handshakes on both sides, a request tag carried to the result, and a saturating cycle count.
//  Sits between a command FIFO and a result consumer; holds one request in flight.
// PARAMETERS
//  W      16  operand/result width (>=2)
//  TAG_W  4   tag width, passed through unchanged
//  CW     16  cycle-counter width, saturating
// PORTS
//  clock              in   1      single clock, rising edge
//  reset              in   1      asynchronous, active-low; all state cleared while low
//  io_in_valid        in   1      request present
//  io_in_ready        out  1      engine can accept a request
//  io_in_bits_a       in   W      operand a (unsigned)
//  io_in_bits_b       in   W      operand b (unsigned)
//  io_in_bits_mode    in   1      0 = subtractive, 1 = binary
//  io_in_bits_tag     in   TAG_W  request tag
//  io_out_valid       out  1      result present
//  io_out_ready       in   1      consumer accepts result
//  io_out_bits_z      out  W      gcd(a,b)
//  io_out_bits_tag    out  TAG_W  tag of the request
//  io_out_bits_cycles out  CW     CALC cycles used, saturates at 2^CW-1
// BEHAVIOUR
//  Reset values: state IDLE; io_in_ready=1; io_out_valid=0; z, tag, cycles = 0.
//  States:
//   IDLE -accept-> CALC
//   CALC -finish-> DONE
//   DONE -out fire-> IDLE, or -out fire and in fire-> CALC
//  io_in_ready = (state==IDLE) | (state==DONE & io_out_ready). Back-to-back requests lose no cycle.
//  Accept (in_valid & in_ready): x<=a, y<=b, k<=0, mode and tag latched, cycle counter <=0.
//  CALC: exactly one action per cycle, first match wins. Counter +1 every CALC cycle, saturating.
//   1 finish: x==y, x==0, or y==0 -> z = (x|y)<<k; go to DONE.
//   2 mode 1, x and y both even -> x>>=1, y>>=1, k+=1.
//   3 mode 1, x even -> x>>=1.
//   4 mode 1, y even -> y>>=1.
//   5 either mode -> larger -= smaller (x>y: x-=y, else y-=x).
//  k width is $clog2(W+1). z never exceeds min(a,b) unless one operand is 0, so no overflow.
//  Zero operands: gcd(a,0)=a, gcd(0,b)=b, gcd(0,0)=0; finish on the first CALC cycle (cycles=1).
//  DONE: io_out_valid=1. z, tag and cycles are held stable until out fire.
//  Holding io_out_ready low stalls indefinitely, with no state change.
//  Inputs are not sampled outside an in fire. Mode and operand changes mid-CALC have no effect.
//  Reset asserted mid-CALC or mid-DONE: request is dropped, outputs take reset values, no result emitted.
// STRUCTURE
//  Package gcd_pkg holds:
//   state enum {IDLE, CALC, DONE}
//   MODE_SUB=1'b0, MODE_BIN=1'b1
//   step-action enum {FIN, HALVE2, HALVEX, HALVEY, SUB}
//  Sub-module gcd_step: combinational single-iteration datapath.
//   in: x, y, k, mode. out: next x, y, k, finish flag, z.
//  Top holds the FSM, the registers, the handshake logic and the counter.
// TESTING
//  T1 mode0 a=360 b=27 tag=5 -> z=9, tag=5, cycles=16; in_ready=0 during CALC.
//  T2 mode1 a=360 b=27 -> z=9, cycles=8. mode1 a=48 b=18 -> z=6 (k=1), cycles=7.
//  T3 a=0 b=0x1234 -> z=0x1234, cycles=1. a=0 b=0 -> z=0, cycles=1. Both modes.
//  T4 out_ready low 5 cycles after out_valid -> z/tag/cycles stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> next request accepted in the same cycle, no bubble.
//  T5 CW=8, mode0 a=1000 b=1 -> z=1, cycles=255 (saturated).
//  T6 reset low in the 3rd CALC cycle of T1 -> out_valid=0, in_ready=1 after release,
//     no result emitted; a following request completes normally.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types for the streaming GCD engine: FSM states, algorithm modes and
// the per-cycle step actions chosen by the datapath.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        FIN,
        HALVE2,
        HALVEX,
        HALVEY,
        SUB
    } step_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: picks a single action (first match wins)
// and produces the next x/y/k, the finish flag and the shifted-back result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_x,
    input  logic [W-1:0]  i_y,
    input  logic [KW-1:0] i_k,
    input  logic          i_mode,
    output logic [W-1:0]  o_x,
    output logic [W-1:0]  o_y,
    output logic [KW-1:0] o_k,
    output logic          o_fin,
    output logic [W-1:0]  o_z
);

    step_t w_action;

    always_comb begin
        w_action = SUB;
        if ((i_x == i_y) || (i_x == '0) || (i_y == '0)) begin
            w_action = FIN;
        end else if ((i_mode == MODE_BIN) && !i_x[0] && !i_y[0]) begin
            w_action = HALVE2;
        end else if ((i_mode == MODE_BIN) && !i_x[0]) begin
            w_action = HALVEX;
        end else if ((i_mode == MODE_BIN) && !i_y[0]) begin
            w_action = HALVEY;
        end
    end

    // The common factor of two removed by HALVE2 is restored on finish via k.
    always_comb begin
        o_x   = i_x;
        o_y   = i_y;
        o_k   = i_k;
        o_fin = 1'b0;
        o_z   = (i_x | i_y) << i_k;
        case (w_action)
            FIN: begin
                o_fin = 1'b1;
            end
            HALVE2: begin
                o_x = i_x >> 1;
                o_y = i_y >> 1;
                o_k = i_k + KW'(1);
            end
            HALVEX: begin
                o_x = i_x >> 1;
            end
            HALVEY: begin
                o_y = i_y >> 1;
            end
            default: begin
                if (i_x > i_y) begin
                    o_x = i_x - i_y;
                end else begin
                    o_y = i_y - i_x;
                end
            end
        endcase
    end

endmodule

// File: rtl/gcd_stream_engine.sv
// Streaming GCD engine: one request in flight, ready/valid on both sides,
// runtime choice of Euclid or Stein per request, saturating cycle count.
module gcd_stream_engine
    import gcd_pkg::*;
#(
    parameter int W     = 16,
    parameter int TAG_W = 4,
    parameter int CW    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [W-1:0]     io_in_bits_a,
    input  logic [W-1:0]     io_in_bits_b,
    input  logic             io_in_bits_mode,
    input  logic [TAG_W-1:0] io_in_bits_tag,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [W-1:0]     io_out_bits_z,
    output logic [TAG_W-1:0] io_out_bits_tag,
    output logic [CW-1:0]    io_out_bits_cycles
);

    localparam int KW = $clog2(W + 1);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_x;
    logic [W-1:0]   r_y;
    logic [KW-1:0]  r_k;
    logic           r_mode;
    logic [TAG_W-1:0] r_tag;
    logic [W-1:0]   r_z;
    logic [CW-1:0]  r_cycles;

    logic [W-1:0]   w_nx;
    logic [W-1:0]   w_ny;
    logic [KW-1:0]  w_nk;
    logic           w_fin;
    logic [W-1:0]   w_z;
    logic           w_in_fire;

    gcd_step #(
        .W  (W),
        .KW (KW)
    ) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_k    (r_k),
        .i_mode (r_mode),
        .o_x    (w_nx),
        .o_y    (w_ny),
        .o_k    (w_nk),
        .o_fin  (w_fin),
        .o_z    (w_z)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Accepting while DONE lets a new request start on the same edge the result leaves.
    always_comb begin
        w_next       = r_state;
        io_in_ready  = (r_state == IDLE) || ((r_state == DONE) && io_out_ready);
        io_out_valid = (r_state == DONE);
        w_in_fire    = io_in_valid && io_in_ready;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_next = CALC;
                end
            end
            CALC: begin
                if (w_fin) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (io_out_ready) begin
                    w_next = w_in_fire ? CALC : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_k      <= '0;
            r_mode   <= MODE_SUB;
            r_tag    <= '0;
            r_z      <= '0;
            r_cycles <= '0;
        end else if (w_in_fire) begin
            r_x      <= io_in_bits_a;
            r_y      <= io_in_bits_b;
            r_k      <= '0;
            r_mode   <= io_in_bits_mode;
            r_tag    <= io_in_bits_tag;
            r_cycles <= '0;
        end else if (r_state == CALC) begin
            r_x <= w_nx;
            r_y <= w_ny;
            r_k <= w_nk;
            if (r_cycles != {CW{1'b1}}) begin
                r_cycles <= r_cycles + CW'(1);
            end
            if (w_fin) begin
                r_z <= w_z;
            end
        end
    end

    assign io_out_bits_z      = r_z;
    assign io_out_bits_tag    = r_tag;
    assign io_out_bits_cycles = r_cycles;

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Scoreboard bench for gcd_stream_engine: expected results are queued at
// request time and popped when a result handshake completes.
module tb_gcd_stream_engine;

    logic        clock = 1'b0;
    logic        reset;

    logic        inValid;
    logic        inReady;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inMode;
    logic [3:0]  inTag;
    logic        outValid;
    logic        outReady;
    logic [15:0] outZ;
    logic [3:0]  outTag;
    logic [15:0] outCycles;

    logic        satInValid;
    logic        satInReady;
    logic [15:0] satInA;
    logic [15:0] satInB;
    logic        satInMode;
    logic [3:0]  satInTag;
    logic        satOutValid;
    logic        satOutReady;
    logic [15:0] satOutZ;
    logic [3:0]  satOutTag;
    logic [7:0]  satOutCycles;

    typedef struct {
        logic [15:0] z;
        logic [3:0]  tag;
        logic [15:0] cycles;
        bit          chkCycles;
    } exp_t;

    exp_t sbq[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clock = ~clock;

    gcd_stream_engine #(.W(16), .TAG_W(4), .CW(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_in_valid        (inValid),
        .io_in_ready        (inReady),
        .io_in_bits_a       (inA),
        .io_in_bits_b       (inB),
        .io_in_bits_mode    (inMode),
        .io_in_bits_tag     (inTag),
        .io_out_valid       (outValid),
        .io_out_ready       (outReady),
        .io_out_bits_z      (outZ),
        .io_out_bits_tag    (outTag),
        .io_out_bits_cycles (outCycles)
    );

    gcd_stream_engine #(.W(16), .TAG_W(4), .CW(8)) dutSat (
        .clock              (clock),
        .reset              (reset),
        .io_in_valid        (satInValid),
        .io_in_ready        (satInReady),
        .io_in_bits_a       (satInA),
        .io_in_bits_b       (satInB),
        .io_in_bits_mode    (satInMode),
        .io_in_bits_tag     (satInTag),
        .io_out_valid       (satOutValid),
        .io_out_ready       (satOutReady),
        .io_out_bits_z      (satOutZ),
        .io_out_bits_tag    (satOutTag),
        .io_out_bits_cycles (satOutCycles)
    );

    // Remainder-based Euclid, used for random operands where only z is checked.
    function automatic logic [15:0] refGcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] t;
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic sendReq(input logic [15:0] a, input logic [15:0] b, input logic mode,
                           input logic [3:0] tag, input logic [15:0] expZ,
                           input logic [15:0] expCyc, input bit chk, input bit push);
        int n;
        @(negedge clock);
        inValid = 1'b1;
        inA     = a;
        inB     = b;
        inMode  = mode;
        inTag   = tag;
        n = 0;
        while (!inReady && n < 50) begin
            @(negedge clock);
            n++;
        end
        nCompared++;
        if (!inReady) begin
            nMismatched++;
            $display("[TB] FAIL accept_timeout tag=%0d: in_ready stayed 0, required 1", tag);
            inValid = 1'b0;
            return;
        end
        if (push) sbq.push_back('{expZ, tag, expCyc, chk});
        @(negedge clock);
        inValid = 1'b0;
    endtask

    task automatic popAndCompare(input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (!outValid && n < budget) begin
            @(negedge clock);
            n++;
        end
        nCompared++;
        if (!outValid) begin
            nMismatched++;
            $display("[TB] FAIL result_timeout: out_valid stayed 0 for %0d cycles, required 1", budget);
            return;
        end
        nCompared++;
        if (sbq.size() == 0) begin
            nMismatched++;
            $display("[TB] FAIL unexpected_result: z=%0d with empty scoreboard", outZ);
        end else begin
            e = sbq.pop_front();
            nCompared++;
            if (outZ !== e.z) begin
                nMismatched++;
                $display("[TB] FAIL z tag=%0d: got %0d, required %0d", e.tag, outZ, e.z);
            end
            nCompared++;
            if (outTag !== e.tag) begin
                nMismatched++;
                $display("[TB] FAIL tag: got %0d, required %0d", outTag, e.tag);
            end
            if (e.chkCycles) begin
                nCompared++;
                if (outCycles !== e.cycles) begin
                    nMismatched++;
                    $display("[TB] FAIL cycles tag=%0d: got %0d, required %0d", e.tag, outCycles, e.cycles);
                end
            end
        end
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inValid = 1'b0; inA = '0; inB = '0; inMode = 1'b0; inTag = '0; outReady = 1'b0;
        satInValid = 1'b0; satInA = '0; satInB = '0; satInMode = 1'b0; satInTag = '0;
        satOutReady = 1'b0;
        #12;
        nCompared++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", inReady, outValid);
        end
        nCompared++;
        if (outZ !== 16'd0 || outTag !== 4'd0 || outCycles !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: z=%0d tag=%0d cycles=%0d, required 0/0/0", outZ, outTag, outCycles);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        nCompared++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_idle: in_ready=%b out_valid=%b, required 1/0", inReady, outValid);
        end
    endtask

    task automatic test_sub();
        logic [15:0] a;
        logic [15:0] b;
        sendReq(16'd360, 16'd27, 1'b0, 4'd5, 16'd9, 16'd16, 1'b1, 1'b1);
        nCompared++;
        if (inReady !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL busy_in_ready: got %b during CALC, required 0", inReady);
        end
        popAndCompare(100);
        sendReq(16'd7, 16'd7, 1'b0, 4'd2, 16'd7, 16'd1, 1'b1, 1'b1);
        popAndCompare(100);
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom_range(1, 3000));
            b = 16'($urandom_range(1, 300));
            sendReq(a, b, 1'b0, 4'(i + 10), refGcd(a, b), 16'd0, 1'b0, 1'b1);
            popAndCompare(5000);
        end
    endtask

    task automatic test_bin();
        logic [15:0] a;
        logic [15:0] b;
        sendReq(16'd360, 16'd27, 1'b1, 4'd6, 16'd9, 16'd8, 1'b1, 1'b1);
        popAndCompare(100);
        sendReq(16'd48, 16'd18, 1'b1, 4'd7, 16'd6, 16'd7, 1'b1, 1'b1);
        popAndCompare(100);
        sendReq(16'd12, 16'd12, 1'b1, 4'd8, 16'd12, 16'd1, 1'b1, 1'b1);
        popAndCompare(100);
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom_range(1, 65535));
            b = 16'($urandom_range(1, 65535));
            sendReq(a, b, 1'b1, 4'(i), refGcd(a, b), 16'd0, 1'b0, 1'b1);
            popAndCompare(200);
        end
    endtask

    task automatic test_zero();
        for (int m = 0; m < 2; m++) begin
            sendReq(16'h0000, 16'h1234, 1'(m), 4'd1, 16'h1234, 16'd1, 1'b1, 1'b1);
            popAndCompare(20);
            sendReq(16'h0000, 16'h0000, 1'(m), 4'd2, 16'h0000, 16'd1, 1'b1, 1'b1);
            popAndCompare(20);
            sendReq(16'h1234, 16'h0000, 1'(m), 4'd3, 16'h1234, 16'd1, 1'b1, 1'b1);
            popAndCompare(20);
        end
    endtask

    task automatic test_stall_back_to_back();
        int   n;
        exp_t e;
        sendReq(16'd360, 16'd27, 1'b0, 4'd3, 16'd9, 16'd16, 1'b1, 1'b1);
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            nCompared++;
            if (outValid !== 1'b1 || outZ !== 16'd9 || outTag !== 4'd3 || outCycles !== 16'd16 || inReady !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold[%0d]: valid=%b z=%0d tag=%0d cycles=%0d in_ready=%b, required 1/9/3/16/0",
                         i, outValid, outZ, outTag, outCycles, inReady);
            end
            if (i < 5) @(negedge clock);
        end
        e = sbq.pop_front();
        nCompared++;
        if (outZ !== e.z) begin
            nMismatched++;
            $display("[TB] FAIL stall_z: got %0d, required %0d", outZ, e.z);
        end
        inValid  = 1'b1;
        inA      = 16'd48;
        inB      = 16'd18;
        inMode   = 1'b1;
        inTag    = 4'd9;
        outReady = 1'b1;
        #1;
        nCompared++;
        if (inReady !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_in_ready: got %b with out_ready=1 in DONE, required 1", inReady);
        end
        sbq.push_back('{16'd6, 4'd9, 16'd7, 1'b1});
        @(negedge clock);
        inValid  = 1'b0;
        outReady = 1'b0;
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_calc: out_valid=%b in_ready=%b, required 0/0", outValid, inReady);
        end
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        nCompared++;
        if (n != 7) begin
            nMismatched++;
            $display("[TB] FAIL b2b_latency: result after %0d cycles, required 7", n);
        end
        popAndCompare(10);
    endtask

    task automatic test_saturate();
        int   n;
        exp_t e;
        @(negedge clock);
        satInValid = 1'b1;
        satInA     = 16'd1000;
        satInB     = 16'd1;
        satInMode  = 1'b0;
        satInTag   = 4'd4;
        nCompared++;
        if (satInReady !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sat_in_ready: got %b, required 1", satInReady);
        end
        sbq.push_back('{16'd1, 4'd4, 16'd255, 1'b1});
        @(negedge clock);
        satInValid = 1'b0;
        n = 0;
        while (!satOutValid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        e = sbq.pop_front();
        nCompared++;
        if (satOutValid !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL sat_timeout: out_valid stayed 0, required 1");
        end else begin
            nCompared++;
            if (satOutZ !== e.z || satOutTag !== e.tag || {8'd0, satOutCycles} !== e.cycles) begin
                nMismatched++;
                $display("[TB] FAIL sat_result: z=%0d tag=%0d cycles=%0d, required %0d/%0d/%0d",
                         satOutZ, satOutTag, satOutCycles, e.z, e.tag, e.cycles);
            end
        end
        satOutReady = 1'b1;
        @(negedge clock);
        satOutReady = 1'b0;
    endtask

    task automatic test_reset_midcalc();
        bit sawValid;
        sendReq(16'd360, 16'd27, 1'b0, 4'd5, 16'd9, 16'd16, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        nCompared++;
        if (outValid !== 1'b0 || inReady !== 1'b1 || outCycles !== 16'd0 || outTag !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL midcalc_reset: valid=%b in_ready=%b cycles=%0d tag=%0d, required 0/1/0/0",
                     outValid, inReady, outCycles, outTag);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (outValid) sawValid = 1'b1;
        end
        nCompared++;
        if (sawValid || inReady !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL dropped_request: saw_valid=%b in_ready=%b, required 0/1", sawValid, inReady);
        end
        sendReq(16'd360, 16'd27, 1'b0, 4'd11, 16'd9, 16'd16, 1'b1, 1'b1);
        popAndCompare(100);
    endtask

    initial begin
        test_reset();
        test_sub();
        test_bin();
        test_zero();
        test_stall_back_to_back();
        test_saturate();
        test_reset_midcalc();
        nCompared++;
        if (sbq.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_leftover: %0d entries, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
